// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// ram_fifo_ctrl_pkg: FSM states, grant type and the push/pop arbiter shared by the RAM FIFO controller.
package ram_fifo_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  typedef struct packed {
    logic wr;
    logic rd;
  } grant_t;

  // A contended cycle goes to whichever access type lost the previous contended cycle.
  function automatic grant_t arbitrate(input logic wr_req, input logic rd_req, input logic last_rd);
    grant_t g;
    g.wr = wr_req && (!rd_req || last_rd);
    g.rd = rd_req && (!wr_req || !last_rd);
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ctrl_ptrs.sv
`default_nettype none
// ram_fifo_ctrl_ptrs: write/read pointers and RAM occupancy, stepped by the grant strobes.
module ram_fifo_ctrl_ptrs #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_gnt_i,
  input  logic                  rd_gnt_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   ram_cnt_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;

  // Pointers wrap naturally at the power-of-two depth; grants are mutually exclusive.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (wr_gnt_i) begin
      wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
      ram_cnt_d = ram_cnt_q + CW'(1);
    end else if (rd_gnt_i) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      ram_cnt_d = ram_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign ram_cnt_o = ram_cnt_q;
  assign full_o    = (ram_cnt_q == DEPTH);
  assign empty_o   = (ram_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ram_fifo_ctrl: valid/ready stream FIFO on an external single-port RAM with a registered
// output word; pushes and pops share the one RAM access per cycle.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_write_o,
  output logic [DATA_WIDTH-1:0] ram_input_o,
  input  logic [DATA_WIDTH-1:0] ram_output_i
);
  localparam int CW = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  last_rd_q, last_rd_d;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  full, empty, wr_req, rd_req;
  grant_t                gnt;

  // Gating with rst_i keeps the producer stalled and the RAM write off during reset.
  assign wr_req = in_valid_i && !full && !rst_i;
  assign rd_req = (state_q == ST_IDLE) && !empty && (!out_valid_q || out_ready_i);
  assign gnt    = arbitrate(wr_req, rd_req, last_rd_q);

  ram_fifo_ctrl_ptrs #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ptrs (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_gnt_i (gnt.wr),
    .rd_gnt_i (gnt.rd),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .ram_cnt_o(ram_cnt),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign in_ready_o  = gnt.wr;
  assign ram_write_o = in_valid_i && in_ready_o;
  assign ram_input_o = in_data_i;
  assign ram_addr_o  = gnt.rd ? rd_ptr : wr_ptr;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign count_o     = ram_cnt + CW'(state_q == ST_FETCH) + CW'(out_valid_q);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_rd_d   = last_rd_q;
    if (wr_req && rd_req) last_rd_d = !last_rd_q;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    // A FETCH capture lands after the pop clear, so it wins when both hit the same edge.
    case (state_q)
      ST_IDLE: begin
        if (gnt.rd) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        out_data_d  = ram_output_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_rd_q   <= last_rd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// tb_ram_fifo_ctrl: controller wired to a behavioural single-port RAM, checked against a queue model.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = AW + 1;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready_o, out_valid_o, ram_write_o;
  logic [DW-1:0] out_data_o, ram_input_o;
  logic [CW-1:0] count_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_output = '0;
  logic [DW-1:0] mem [D];

  int total = 0;
  int bad   = 0;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
    .count_o(count_o),
    .ram_addr_o(ram_addr_o), .ram_write_o(ram_write_o), .ram_input_o(ram_input_o),
    .ram_output_i(ram_output)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_write_o) mem[ram_addr_o] <= ram_input_o;
    ram_output <= mem[ram_addr_o];
  end

  // Reference model: RAM contents as a queue, one in-flight read, one output word.
  logic [DW-1:0] m_ram [$];
  logic [DW-1:0] exp_pop [$];
  bit            m_fetch = 0;
  logic [DW-1:0] m_fdata = '0;
  bit            m_ov = 0;
  logic [DW-1:0] m_od = '0;
  bit            m_last_rd = 0;

  function automatic bit m_wr_req();
    return in_valid && (m_ram.size() < D) && !rst;
  endfunction
  function automatic bit m_rd_req();
    return !m_fetch && (m_ram.size() != 0) && (!m_ov || out_ready);
  endfunction
  function automatic bit m_wr_gnt();
    return m_wr_req() && (!m_rd_req() || m_last_rd);
  endfunction
  function automatic bit m_rd_gnt();
    return m_rd_req() && (!m_wr_req() || !m_last_rd);
  endfunction
  function automatic int m_count();
    return m_ram.size() + (m_fetch ? 1 : 0) + (m_ov ? 1 : 0);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit wg, rg, both;
    if (rst) begin
      m_ram.delete(); exp_pop.delete();
      m_fetch = 0; m_ov = 0; m_od = '0; m_last_rd = 0;
    end else begin
      wg = m_wr_gnt(); rg = m_rd_gnt(); both = m_wr_req() && m_rd_req();
      if (m_fetch) begin
        m_ov = 1; m_od = m_fdata; m_fetch = 0;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (rg) begin m_fdata = m_ram.pop_front(); m_fetch = 1; end
      if (wg) begin m_ram.push_back(in_data); exp_pop.push_back(in_data); end
      if (both) m_last_rd = !m_last_rd;
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r;
    #1;
  endtask

  task automatic flush(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, '0, 1'b1);
      if (count_o == '0 && !out_valid_o) begin ok = 1; break; end
      if (out_valid_o && exp_pop.size() != 0) void'(exp_pop.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if (in_ready_o !== 1'b0 || ram_write_o !== 1'b0 || out_valid_o !== 1'b0 || count_o !== '0 || out_data_o !== '0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b ram_write=%b out_valid=%b count=%0d out_data=%h, want 0 0 0 0 00",
               in_ready_o, ram_write_o, out_valid_o, count_o, out_data_o);
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    step(1'b1, 8'h11, 1'b0);
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_push_accept: in_ready=%b want 1", in_ready_o); end
    step(1'b0, '0, 1'b0);
    @(posedge clk); #2;
    total++;
    if (count_o !== CW'(1) || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_in_fetch: count=%0d out_valid=%b, want 1 0", count_o, out_valid_o);
    end
    in_valid = 1'b1; rst = 1'b1; #1;
    total++;
    if (out_valid_o !== 1'b0 || count_o !== '0 || in_ready_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid_fetch: out_valid=%b count=%0d in_ready=%b, want 0 0 0", out_valid_o, count_o, in_ready_o);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready_o); end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1);
      total++;
      if (out_valid_o !== 1'b0 || count_o !== '0) begin
        bad++; $display("FAIL reset_discard: out_valid=%b count=%0d, want 0 0", out_valid_o, count_o);
      end
    end
  endtask

  task automatic test_single_push();
    bit ok;
    step(1'b1, 8'h2A, 1'b0);
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL single_accept: in_ready=%b want 1", in_ready_o); end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b0);
      total++;
      if (out_valid_o !== 1'(k >= 2) || count_o !== CW'(1)) begin
        bad++; $display("FAIL single_latency[%0d]: out_valid=%b count=%0d, want %b 1", k, out_valid_o, count_o, k >= 2);
      end
      if (k >= 2) begin
        total++;
        if (out_data_o !== 8'h2A) begin bad++; $display("FAIL single_data: out_data=%h want 2a", out_data_o); end
      end
    end
    flush(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_flush: count=%0d want 0", count_o); end
  endtask

  task automatic test_fill();
    int n = 0;
    for (int c = 0; c < 2000 && n < D + 1; c++) begin
      step(1'b1, DW'(n), 1'b0);
      total++;
      if (in_ready_o !== m_wr_gnt()) begin
        bad++; $display("FAIL fill_ready: in_ready=%b want %b", in_ready_o, m_wr_gnt());
      end
      if (in_ready_o) n++;
    end
    total++;
    if (n != D + 1) begin bad++; $display("FAIL fill_accepted: accepted=%0d want %0d", n, D + 1); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'hEE, 1'b0);
      total++;
      if (in_ready_o !== 1'b0 || ram_write_o !== 1'b0 || count_o !== CW'(D + 1)) begin
        bad++; $display("FAIL fill_full: in_ready=%b ram_write=%b count=%0d, want 0 0 %0d", in_ready_o, ram_write_o, count_o, D + 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    int n = 0;
    for (int c = 0; c < 2000 && n < D + 1; c++) begin
      step(1'b0, '0, 1'b1);
      if (out_valid_o) begin
        total++;
        if (out_data_o !== DW'(n)) begin bad++; $display("FAIL drain_order[%0d]: out_data=%h want %h", n, out_data_o, DW'(n)); end
        if (exp_pop.size() != 0) void'(exp_pop.pop_front());
        n++;
      end
    end
    total++;
    if (n != D + 1) begin bad++; $display("FAIL drain_count: popped=%0d want %0d", n, D + 1); end
    step(1'b0, '0, 1'b1);
    total++;
    if (out_valid_o !== 1'b0 || count_o !== '0) begin
      bad++; $display("FAIL drain_empty: out_valid=%b count=%0d, want 0 0", out_valid_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    int pre = 0, wr = 0, rd = 0;
    bit ok;
    for (int c = 0; c < 50 && pre < 4; c++) begin
      step(1'b1, DW'($urandom), 1'b0);
      if (in_ready_o) pre++;
    end
    for (int c = 0; c < 40; c++) begin
      step(1'b1, DW'($urandom), 1'b1);
      total++;
      if (in_ready_o !== m_wr_gnt() || count_o !== CW'(m_count())) begin
        bad++; $display("FAIL b2b_grant: in_ready=%b count=%0d, want %b %0d", in_ready_o, count_o, m_wr_gnt(), m_count());
      end
      if (in_ready_o) wr++;
      if (out_valid_o) begin
        total++;
        if (exp_pop.size() == 0 || out_data_o !== exp_pop[0]) begin
          bad++; $display("FAIL b2b_order: out_data=%h want %h", out_data_o, exp_pop.size() ? exp_pop[0] : 8'hxx);
        end
        if (exp_pop.size() != 0) void'(exp_pop.pop_front());
        rd++;
      end
    end
    total++;
    if (wr < 10 || rd < 10) begin bad++; $display("FAIL b2b_starvation: writes=%0d pops=%0d, want both >= 10", wr, rd); end
    flush(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_flush: count=%0d want 0", count_o); end
  endtask

  task automatic test_stall();
    bit got = 0, found = 0, ok;
    logic [DW-1:0] held;
    for (int c = 0; c < 20 && !got; c++) begin
      step(1'(c < 3), DW'($urandom), 1'b0);
      got = out_valid_o;
    end
    total++;
    if (!got) begin bad++; $display("FAIL stall_head: out_valid=%b want 1", out_valid_o); end
    held = out_data_o;
    for (int k = 0; k < 10; k++) begin
      step((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
      total++;
      if (out_valid_o !== 1'b1 || out_data_o !== held || out_data_o !== exp_pop[0]) begin
        bad++; $display("FAIL stall_hold: out_valid=%b out_data=%h, want 1 %h", out_valid_o, out_data_o, exp_pop[0]);
      end
    end
    step(1'b0, '0, 1'b1);
    void'(exp_pop.pop_front());
    for (int k = 0; k < 2 && !found; k++) begin
      step(1'b0, '0, 1'b0);
      found = out_valid_o;
    end
    total++;
    if (!found || exp_pop.size() == 0 || out_data_o !== exp_pop[0]) begin
      bad++; $display("FAIL stall_next_head: out_valid=%b out_data=%h, want 1 %h", out_valid_o, out_data_o,
                      exp_pop.size() ? exp_pop[0] : 8'hxx);
    end
    flush(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_flush: count=%0d want 0", count_o); end
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 1500; c++) begin
      step((c < 750) ? 1'(($urandom % 4) != 0) : 1'(($urandom % 4) == 0), DW'($urandom), 1'($urandom_range(0, 1)));
      total++;
      if (in_ready_o !== m_wr_gnt() || ram_write_o !== m_wr_gnt() || out_valid_o !== m_ov || count_o !== CW'(m_count())) begin
        bad++;
        $display("FAIL random_state[%0d]: in_ready=%b ram_write=%b out_valid=%b count=%0d, want %b %b %b %0d",
                 c, in_ready_o, ram_write_o, out_valid_o, count_o, m_wr_gnt(), m_wr_gnt(), m_ov, m_count());
      end
      if (out_valid_o && out_ready) begin
        total++;
        if (exp_pop.size() == 0 || out_data_o !== exp_pop[0] || out_data_o !== m_od) begin
          bad++; $display("FAIL random_data[%0d]: out_data=%h want %h", c, out_data_o, exp_pop.size() ? exp_pop[0] : 8'hxx);
        end
        if (exp_pop.size() != 0) void'(exp_pop.pop_front());
      end
    end
    flush(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL random_flush: count=%0d want 0", count_o); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_drain();
    test_back_to_back();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
